// File: rtl/alu_operand_stage.sv
// ALU operand stage: A/B select with EX/MEM forwarding, load-use stall and a valid/ready output register.
// Optional forwarded-operand counter enabled by ALU_OPERAND_FWD_CNT_EN.
module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 5,
    parameter int IMM_W  = 12,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [PC_W-1:0]   pc_const,
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        asel,
    input  logic [1:0]        bsel,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wen,
    input  logic              ex_load,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wen,
    input  logic [DATA_W-1:0] mem_result,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef ALU_OPERAND_FWD_CNT_EN
    output logic [15:0]       fwd_count,
`endif
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B
);

    typedef enum logic {
        S_RUN,
        S_STALL
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_valid;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;

    logic                w_a_ex;
    logic                w_a_mem;
    logic                w_b_ex;
    logic                w_b_mem;
    logic [DATA_W-1:0]   w_rs1_val;
    logic [DATA_W-1:0]   w_rs2_val;
    logic                w_a_uses_rs;
    logic                w_b_uses_rs;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic                w_hazard;
    logic                w_accept;

    // Register 0 is hardwired, so it never matches a producer.
    assign w_a_ex  = (rs1 != '0) && ex_wen && !ex_load && (ex_rd == rs1);
    assign w_a_mem = (rs1 != '0) && mem_wen && (mem_rd == rs1);
    assign w_b_ex  = (rs2 != '0) && ex_wen && !ex_load && (ex_rd == rs2);
    assign w_b_mem = (rs2 != '0) && mem_wen && (mem_rd == rs2);

    assign w_rs1_val = w_a_ex ? ex_result : (w_a_mem ? mem_result : rd1);
    assign w_rs2_val = w_b_ex ? ex_result : (w_b_mem ? mem_result : rd2);

    assign w_a_uses_rs = (asel == 2'b00) || (asel == 2'b11);
    assign w_b_uses_rs = (bsel == 2'b00) || (bsel == 2'b11);

    always_comb begin
        w_a = w_rs1_val;
        unique case (asel)
            2'b01:   w_a = {{(DATA_W-PC_W){1'b0}}, pc_const};
            2'b10:   w_a = '0;
            default: w_a = w_rs1_val;
        endcase
    end

    always_comb begin
        w_b = w_rs2_val;
        unique case (bsel)
            2'b01:   w_b = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
            2'b10:   w_b = {{(DATA_W-3){1'b0}}, 3'b100};
            default: w_b = w_rs2_val;
        endcase
    end

    // A load in EX has no data yet; only sources actually selected can stall.
    assign w_hazard = in_valid && ex_wen && ex_load && (ex_rd != '0) &&
                      (((ex_rd == rs1) && w_a_uses_rs) ||
                       ((ex_rd == rs2) && w_b_uses_rs));

    assign in_ready  = (!r_valid || out_ready) && !w_hazard && !flush;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_valid;
    assign A         = r_a;
    assign B         = r_b;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RUN:   w_state_nxt = w_hazard ? S_STALL : S_RUN;
            S_STALL: w_state_nxt = w_hazard ? S_STALL : S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
        if (flush)
            w_state_nxt = S_RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_RUN;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_a     <= w_a;
            r_b     <= w_b;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef ALU_OPERAND_FWD_CNT_EN
    logic [15:0] r_fwd_cnt;
    logic [1:0]  w_fwd_n;
    logic [16:0] w_fwd_sum;

    assign w_fwd_n = {1'b0, w_a_uses_rs && (w_a_ex || w_a_mem)} +
                     {1'b0, w_b_uses_rs && (w_b_ex || w_b_mem)};
    assign w_fwd_sum = {1'b0, r_fwd_cnt} + {15'd0, w_fwd_n};
    assign fwd_count = r_fwd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_fwd_cnt <= '0;
        else if (w_accept)
            r_fwd_cnt <= w_fwd_sum[16] ? 16'hFFFF : w_fwd_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus
// randomized traffic against a behavioural operand/handshake model.
module tb_alu_operand_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  pc_const;
    logic [11:0] imm;
    logic [1:0]  asel;
    logic [1:0]  bsel;
    logic [4:0]  ex_rd;
    logic        ex_wen;
    logic        ex_load;
    logic [31:0] ex_result;
    logic [4:0]  mem_rd;
    logic        mem_wen;
    logic [31:0] mem_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A;
    logic [31:0] B;
`ifdef ALU_OPERAND_FWD_CNT_EN
    logic [15:0] fwd_count;
`endif

    int checks = 0;
    int errors = 0;

    alu_operand_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rd1        (rd1),
        .rd2        (rd2),
        .rs1        (rs1),
        .rs2        (rs2),
        .pc_const   (pc_const),
        .imm        (imm),
        .asel       (asel),
        .bsel       (bsel),
        .ex_rd      (ex_rd),
        .ex_wen     (ex_wen),
        .ex_load    (ex_load),
        .ex_result  (ex_result),
        .mem_rd     (mem_rd),
        .mem_wen    (mem_wen),
        .mem_result (mem_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef ALU_OPERAND_FWD_CNT_EN
        .fwd_count  (fwd_count),
`endif
        .A          (A),
        .B          (B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; rd1 = 0; rd2 = 0; rs1 = 0; rs2 = 0;
        pc_const = 0; imm = 0; asel = 2'b10; bsel = 2'b10;
        ex_rd = 0; ex_wen = 0; ex_load = 0; ex_result = 0;
        mem_rd = 0; mem_wen = 0; mem_result = 0; out_ready = 1;
    endtask

    // Reference: operand value a source register delivers after bypassing.
    function automatic logic [31:0] src_val(input logic [4:0] s,
                                            input logic [31:0] rf);
        if (s != 0 && ex_wen && !ex_load && ex_rd == s) return ex_result;
        if (s != 0 && mem_wen && mem_rd == s) return mem_result;
        return rf;
    endfunction

    function automatic logic [31:0] model_a();
        case (asel)
            2'b01:   return 32'(pc_const);
            2'b10:   return 32'd0;
            default: return src_val(rs1, rd1);
        endcase
    endfunction

    function automatic logic [31:0] model_b();
        case (bsel)
            2'b01:   return 32'($signed(imm));
            2'b10:   return 32'd4;
            default: return src_val(rs2, rd2);
        endcase
    endfunction

    function automatic bit model_hazard();
        bit ua, ub;
        ua = (asel == 2'b00 || asel == 2'b11);
        ub = (bsel == 2'b00 || bsel == 2'b11);
        return in_valid && ex_wen && ex_load && ex_rd != 0 &&
               ((ex_rd == rs1 && ua) || (ex_rd == rs2 && ub));
    endfunction

    task automatic test_reset();
        idle();
        rst = 1;
        #2;
        checks++;
        if (out_valid !== 1'b0 || A !== 32'd0 || B !== 32'd0) begin
            errors++;
            $display("FAIL reset: valid=%b A=%h B=%h, expected 0/0/0", out_valid, A, B);
        end
        tick();
        #2 rst = 0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_extend();
        idle();
        asel = 2'b01; pc_const = 5'h1F; bsel = 2'b01; imm = 12'hFFF;
        in_valid = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ext_ready: in_ready=%b expected 1", in_ready);
        end
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || A !== 32'h0000001F || B !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL ext_ops: valid=%b A=%h B=%h, expected 1/0000001f/ffffffff",
                     out_valid, A, B);
        end
        imm = 12'h7FF; bsel = 2'b01; in_valid = 1;
        tick();
        in_valid = 0;
        checks++;
        if (B !== 32'h000007FF || A !== 32'h0000001F) begin
            errors++;
            $display("FAIL ext_pos: A=%h B=%h, expected 0000001f/000007ff", A, B);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || B !== 32'h000007FF) begin
            errors++;
            $display("FAIL drain: valid=%b B=%h, expected 0/000007ff", out_valid, B);
        end
    endtask

    task automatic test_forward();
        idle();
        rs1 = 3; asel = 2'b00; rd1 = 32'h11111111;
        ex_wen = 1; ex_rd = 3; ex_result = 32'hAAAA0000;
        mem_wen = 1; mem_rd = 3; mem_result = 32'h00005555;
        in_valid = 1;
        tick();
        checks++;
        if (A !== 32'hAAAA0000 || B !== 32'd4) begin
            errors++;
            $display("FAIL fwd_ex: A=%h B=%h, expected aaaa0000/00000004", A, B);
        end
        ex_wen = 0;
        tick();
        checks++;
        if (A !== 32'h00005555) begin
            errors++;
            $display("FAIL fwd_mem: A=%h expected 00005555", A);
        end
        rs1 = 0; ex_wen = 1; ex_rd = 0; mem_rd = 0;
        tick();
        checks++;
        if (A !== 32'h11111111) begin
            errors++;
            $display("FAIL fwd_r0: A=%h expected 11111111", A);
        end
        rs1 = 3; ex_rd = 3; asel = 2'b10; rs2 = 3; bsel = 2'b11; rd2 = 32'h22;
        tick();
        in_valid = 0;
        checks++;
        if (A !== 32'd0 || B !== 32'hAAAA0000) begin
            errors++;
            $display("FAIL fwd_b: A=%h B=%h, expected 00000000/aaaa0000", A, B);
        end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        ex_load = 1; ex_wen = 1; ex_rd = 7; rs2 = 7; bsel = 2'b00;
        rd2 = 32'hDEAD; in_valid = 1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall: in_ready=%b expected 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lu_noacc: valid=%b expected 0", out_valid);
        end
        ex_load = 0; ex_wen = 0; ex_rd = 0;
        mem_rd = 7; mem_wen = 1; mem_result = 32'h1234;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lu_release: in_ready=%b expected 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || B !== 32'h1234) begin
            errors++;
            $display("FAIL lu_data: valid=%b B=%h, expected 1/00001234", out_valid, B);
        end
        mem_wen = 0;
        ex_load = 1; ex_wen = 1; ex_rd = 7; bsel = 2'b10;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lu_unsel: in_ready=%b expected 1", in_ready);
        end
        tick();
        in_valid = 0;
        checks++;
        if (B !== 32'd4 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL lu_const: valid=%b B=%h, expected 1/00000004", out_valid, B);
        end
        tick();
    endtask

    task automatic test_backpressure();
        idle();
        asel = 2'b01; pc_const = 5'h0A; bsel = 2'b01; imm = 12'h00B;
        in_valid = 1; out_ready = 0;
        tick();
        pc_const = 5'h15; imm = 12'h800;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                A !== 32'h0A || B !== 32'h0B) begin
                errors++;
                $display("FAIL bp_hold%0d: rdy=%b valid=%b A=%h B=%h, expected 0/1/0000000a/0000000b",
                         i, in_ready, out_valid, A, B);
            end
            tick();
        end
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b expected 1", in_ready);
        end
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || A !== 32'h15 || B !== 32'hFFFFF800) begin
            errors++;
            $display("FAIL bp_b2b: valid=%b A=%h B=%h, expected 1/00000015/fffff800",
                     out_valid, A, B);
        end
        tick();
    endtask

    task automatic test_flush();
        idle();
        asel = 2'b01; pc_const = 5'h03; in_valid = 1; out_ready = 0;
        tick();
        pc_const = 5'h09; flush = 1; out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_rdy: in_ready=%b expected 0", in_ready);
        end
        tick();
        flush = 0; in_valid = 0;
        checks++;
        if (out_valid !== 1'b0 || A !== 32'h03) begin
            errors++;
            $display("FAIL flush: valid=%b A=%h, expected 0/00000003", out_valid, A);
        end
    endtask

    task automatic test_rst_mid();
        idle();
        asel = 2'b01; pc_const = 5'h05; in_valid = 1; out_ready = 0;
        tick();
        ex_load = 1; ex_wen = 1; ex_rd = 4; rs1 = 4; asel = 2'b00;
        tick();
        #2 rst = 1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || A !== 32'd0) begin
            errors++;
            $display("FAIL rst_async: valid=%b A=%h, expected 0/00000000", out_valid, A);
        end
        #3 rst = 0;
        idle();
        asel = 2'b01; pc_const = 5'h06; in_valid = 1;
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || A !== 32'h06) begin
            errors++;
            $display("FAIL rst_recover: valid=%b A=%h, expected 1/00000006", out_valid, A);
        end
        tick();
    endtask

`ifdef ALU_OPERAND_FWD_CNT_EN
    task automatic test_fwd_count();
        rst = 1;
        #2 rst = 0;
        idle();
        rs1 = 1; rs2 = 2; asel = 2'b00; bsel = 2'b11;
        ex_wen = 1; ex_rd = 1; ex_result = 32'h10;
        mem_wen = 1; mem_rd = 2; mem_result = 32'h20;
        in_valid = 1;
        for (int i = 0; i < 3; i++) tick();
        in_valid = 0;
        checks++;
        if (fwd_count !== 16'd6) begin
            errors++;
            $display("FAIL fwd_cnt: got %0d expected 6", fwd_count);
        end
        flush = 1;
        tick();
        flush = 0;
        checks++;
        if (fwd_count !== 16'd6) begin
            errors++;
            $display("FAIL fwd_cnt_flush: got %0d expected 6", fwd_count);
        end
        in_valid = 1;
        for (int i = 0; i < 32766; i++) tick();
        checks++;
        if (fwd_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL fwd_cnt_sat: got %h expected ffff", fwd_count);
        end
        tick();
        in_valid = 0;
        checks++;
        if (fwd_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL fwd_cnt_hold: got %h expected ffff", fwd_count);
        end
    endtask
`endif

    task automatic test_random();
        logic        ev;
        logic [31:0] ea, eb, na, nb;
        bit          erdy, acc;
        idle();
        rst = 1;
        #2 rst = 0;
        ev = 0; ea = 0; eb = 0;
        for (int n = 0; n < 400; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            rs1        = 5'($urandom_range(0, 3));
            rs2        = 5'($urandom_range(0, 3));
            ex_rd      = 5'($urandom_range(0, 3));
            mem_rd     = 5'($urandom_range(0, 3));
            ex_wen     = 1'($urandom);
            ex_load    = ($urandom_range(0, 3) == 0);
            mem_wen    = 1'($urandom);
            asel       = 2'($urandom);
            bsel       = 2'($urandom);
            rd1        = $urandom;
            rd2        = $urandom;
            ex_result  = $urandom;
            mem_result = $urandom;
            pc_const   = 5'($urandom);
            imm        = 12'($urandom);
            #1;
            erdy = (!ev || out_ready) && !model_hazard() && !flush;
            acc  = in_valid && erdy;
            na = model_a();
            nb = model_b();
            checks++;
            if (in_ready !== erdy) begin
                errors++;
                $display("FAIL rnd_rdy[%0d]: got %b expected %b", n, in_ready, erdy);
            end
            if (flush) ev = 0;
            else if (acc) begin ev = 1; ea = na; eb = nb; end
            else if (out_ready) ev = 0;
            tick();
            checks++;
            if (out_valid !== ev || A !== ea || B !== eb) begin
                errors++;
                $display("FAIL rnd_out[%0d]: valid=%b A=%h B=%h expected %b/%h/%h",
                         n, out_valid, A, B, ev, ea, eb);
            end
        end
        idle();
        tick();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_extend();
        test_forward();
        test_load_use();
        test_backpressure();
        test_flush();
        test_rst_mid();
`ifdef ALU_OPERAND_FWD_CNT_EN
        test_fwd_count();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered, parametrised successor to the ALU operand-A select for the 32-bit RISC core.
- Selects both ALU operands (A and B) from register file, PC constant, immediate or constants, with EX/MEM result forwarding.
- Holds the selected operands in a one-entry valid/ready pipeline register between decode and the ALU.
- Detects load-use hazards and back-pressures decode until the hazard clears.

Parameters:
- DATA_W, 32, operand and result width.
- PC_W, 5, width of pc_const from the offset adder; zero-extended to DATA_W.
- IMM_W, 12, immediate width; sign-extended to DATA_W.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous squash of the held and incoming operands.
- in_valid  in  1  decode presents an operation.
- in_ready  out  1  stage accepts the operation this cycle.
- rd1  in  DATA_W  register file read port 1.
- rd2  in  DATA_W  register file read port 2.
- rs1  in  REG_AW  source address for rd1.
- rs2  in  REG_AW  source address for rd2.
- pc_const  in  PC_W  PC value from the offset adder.
- imm  in  IMM_W  immediate field.
- asel  in  2  A select: 00 rs1 path, 01 zext(pc_const), 10 zero, 11 rs1 path.
- bsel  in  2  B select: 00 rs2 path, 01 sext(imm), 10 constant 4, 11 rs2 path.
- ex_rd  in  REG_AW  EX-stage destination register.
- ex_wen  in  1  EX stage writes ex_rd.
- ex_load  in  1  EX-stage operation is a load; its result is not yet available.
- ex_result  in  DATA_W  EX-stage result.
- mem_rd  in  REG_AW  MEM-stage destination register.
- mem_wen  in  1  MEM stage writes mem_rd.
- mem_result  in  DATA_W  MEM-stage result.
- out_valid  out  1  A and B are valid.
- out_ready  in  1  ALU consumes the operands.
- A  out  DATA_W  registered operand A.
- B  out  DATA_W  registered operand B.

Behaviour:
- Reset (async, rst=1): out_valid=0, A=0, B=0, hazard state = RUN, forward counter = 0 (if compiled in).
- Forwarding for a source register s with read value rdN, evaluated combinationally:
  - If s!=0, ex_wen=1, ex_load=0 and ex_rd==s: use ex_result.
  - Else if s!=0, mem_wen=1 and mem_rd==s: use mem_result.
  - Else: use rdN.
  - EX has priority over MEM. Register 0 is never forwarded.
- Load-use hazard: in_valid=1, ex_wen=1, ex_load=1, ex_rd!=0, and either ex_rd==rs1 with asel in {00,11}, or ex_rd==rs2 with bsel in {00,11}. A source that is not selected never causes a hazard.
- FSM:
  - RUN to STALL when a hazard is detected.
  - STALL to RUN on the next cycle; the load has moved to MEM and the forwarding path covers it.
  - In STALL, the hazard is re-evaluated each cycle.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Accept (in_valid && in_ready): A and B load the selected values on the next edge and out_valid=1. Latency is 1 cycle.
- out_valid && out_ready && no accept: out_valid goes to 0 and A/B hold their values.
- out_valid && !out_ready: A, B and out_valid hold and are stable; in_ready=0.
- Consume and accept in the same cycle: back-to-back transfer, out_valid stays 1.
- flush=1: out_valid goes to 0 next edge, no accept that cycle, FSM goes to RUN; A and B keep their values. flush overrides out_ready and in_valid.
- Width rules:
  - pc_const is zero-extended: {DATA_W-PC_W zeros, pc_const}.
  - imm is sign-extended from bit IMM_W-1.
  - Constant 4 is DATA_W wide.
- rst asserted mid-transfer discards the held operand immediately; out_valid drops asynchronously.

Optional Feature:
- Macro: ALU_OPERAND_FWD_CNT_EN.
- Defined:
  - Adds output fwd_count [15:0].
  - Increments by the number of forwarded selected operands (0, 1 or 2) on each accepted operation.
  - Saturates at 16'hFFFF. Cleared by rst only, not by flush.
- Undefined:
  - No port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset then asel=01, pc_const=5'h1F, bsel=01, imm=12'hFFF, in_valid=1 -> next cycle out_valid=1, A=32'h0000001F, B=32'hFFFFFFFF.
- rs1=3, asel=00, ex_wen=1, ex_rd=3, ex_result=32'hAAAA0000, mem_wen=1, mem_rd=3, mem_result=32'h5555 -> A=32'hAAAA0000 (EX wins). Repeat with rs1=0 -> A=rd1.
- ex_load=1, ex_wen=1, ex_rd=7, rs2=7, bsel=00, in_valid=1 -> in_ready=0 for 1 cycle. Next cycle with mem_rd=7, mem_wen=1, mem_result=32'h1234 -> accepted, B=32'h1234. Same case with bsel=10 -> no stall, B=4.
- out_valid=1, out_ready=0 for 3 cycles with new in_valid data -> A/B unchanged, in_ready=0. Then out_ready=1 -> new operands appear the next cycle.
- flush=1 with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, nothing accepted. rst asserted mid-stall -> out_valid=0 immediately, FSM in RUN.
- With ALU_OPERAND_FWD_CNT_EN: 3 accepts each forwarding both operands -> fwd_count=6. Preload near saturation -> holds 16'hFFFF.
